snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter SIZE_X, default 10, field width in cells (6..255).
REQ-002 SHALL have parameter SIZE_Y, default 10, field height in cells (2..255); N = SIZE_X*SIZE_Y.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick  input  1  move strobe; sampled only in IDLE.
REQ-006 SHALL have port key  input  2  player request: 00 w (y-1), 01 a (x-1), 11 s (y+1), 10 d (x+1).
REQ-007 SHALL have port dead  input  1  collision verdict from checker.
REQ-008 SHALL have port grow  input  1  food verdict from checker.
REQ-009 SHALL have port check  output  1  one-cycle request to checker.
REQ-010 SHALL have port dir  output  2  current heading, key encoding, driven to the checker key input.
REQ-011 SHALL have port snake_xy  output  16*N  segment i at [16i+15:16i], x in low byte, y in high byte; segment 0 = head.
REQ-012 SHALL have port field  output  2*N  cell (x,y) at bits [2(x+y*SIZE_X)+1 : 2(x+y*SIZE_X)]: 00 empty, 01 body, 10 food.
REQ-013 SHALL have port length  output  16  live segment count.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE and OVER.
REQ-015 SHALL have port game_over  output  1  high in OVER.

Function
REQ-016 SHALL implement FSM IDLE -> CHECK -> WAIT -> APPLY -> (FOOD) -> IDLE, plus terminal OVER.
REQ-017 IDLE: on tick=1, latch key into dir unless key is the exact reverse of dir (00/11, 01/10), then go to CHECK.
REQ-018 CHECK: assert check for exactly one cycle; go to WAIT.
REQ-019 WAIT: one idle cycle for the registered checker verdict; go to APPLY.
REQ-020 APPLY: sample dead/grow; dead=1 goes to OVER with no snake/field change; dead has priority over grow.
REQ-021 APPLY with dead=0: shift segments i -> i+1, write the new head = old head stepped by dir, set its field cell to 01.
REQ-022 Coordinate step SHALL wrap modulo SIZE_X/SIZE_Y (0-1 -> SIZE-1, SIZE-1+1 -> 0).
REQ-023 APPLY with grow=0: clear the old tail cell to 00 and zero the vacated slot; length unchanged; go to IDLE.
REQ-024 APPLY with grow=1: keep the tail; length+1; if the new length = N go to OVER, else go to FOOD.
REQ-025 Free-running scan pointer fp SHALL count 0..N-1 every clock with wrap, from 0 at reset.
REQ-026 FOOD: on entry, load cursor = fp; each cycle, if the cursor cell is 00, write 10 and go to IDLE, else cursor+1 mod N; completes within N cycles.
REQ-027 OVER: hold all outputs; ignore tick; leave only via reset.
REQ-028 tick outside IDLE SHALL be ignored, not queued.
REQ-029 Segment slots at index >= length SHALL read as 0.

Reset
REQ-030 rst=0 at a clock edge SHALL return to IDLE from any state, including mid-FOOD, with: check=0, busy=0, game_over=0, dir=10, length=3.
REQ-031 Reset snake SHALL be (2,Y0),(1,Y0),(0,Y0) with Y0=SIZE_Y/2; those field cells 01, food at (SIZE_X/2,Y0), all other cells 00, fp=0.

Structure
REQ-032 Shared package snake_pkg SHALL hold cell codes (EMPTY/BODY/FOOD), key codes, FSM state enum and the 16-bit xy pack/unpack width constants, for reuse by game_behavior.
REQ-033 Food search SHALL be one sub-module snake_food_scan (fp counter, cursor, empty-cell search, done pulse).

Verification (SIZE_X=SIZE_Y=10)
REQ-034 Reset -> head (2,5), length 3, cells (0..2,5)=01, (5,5)=10, dir=10, busy=0.
REQ-035 tick, key=10, dead=grow=0 -> check high exactly at cycle T+1 only, head (3,5) at T+4, cell (0,5)=00, length 3.
REQ-036 Head (4,5), tick key=10, grow=1 -> head (5,5), length 4, tail kept, exactly one new 10 cell placed at the first empty cell at/after fp, busy drops.
REQ-037 dir=10, tick with key=01 -> dir stays 10; with dead=1 in APPLY -> game_over=1, snake unchanged, later ticks ignored, rst=0 recovers to the REQ-034 state.
REQ-038 tick pulsed during CHECK/WAIT/FOOD -> no extra check pulse, no extra move; rst=0 during FOOD -> exact REQ-034 state next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake engine and its companions
// (game_behavior and friends). It holds the cell codes, the key/heading codes,
// the engine FSM states and the 16-bit xy packing (x in the low byte, y in the high byte).
package snake_pkg;

  localparam int XY_W    = 16;
  localparam int COORD_W = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BODY  = 2'b01;
  localparam logic [1:0] CELL_FOOD  = 2'b10;

  localparam logic [1:0] KEY_W = 2'b00;  // y-1
  localparam logic [1:0] KEY_A = 2'b01;  // x-1
  localparam logic [1:0] KEY_D = 2'b10;  // x+1
  localparam logic [1:0] KEY_S = 2'b11;  // y+1

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_WAIT, ST_APPLY, ST_FOOD, ST_OVER
  } state_e;

  function automatic logic [XY_W-1:0] pack_xy(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

  function automatic logic [COORD_W-1:0] xy_x(input logic [XY_W-1:0] xy);
    return xy[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] xy_y(input logic [XY_W-1:0] xy);
    return xy[XY_W-1:COORD_W];
  endfunction

  // The encoding puts opposite headings at bitwise complements (W/S, A/D).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/snake_food_scan.sv
// snake_food_scan: places new food.
// It holds a free-running scan pointer fp that counts 0..N-1 and wraps.
// When start is high, the cursor loads fp. While active is high, the cursor
// walks forward through the field, wrapping at N, until it reaches an empty cell.
//   clk, rst  : clock, synchronous active-low reset
//   start     : load cursor from fp on this edge
//   active    : search in progress
//   field     : current field, 2 bits per cell
//   done      : cursor sits on an empty cell this cycle (combinational)
//   idx       : cursor cell index
module snake_food_scan
  import snake_pkg::*;
#(
  parameter int N  = 100,
  parameter int PW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           active,
  input  logic [2*N-1:0] field,
  output logic           done,
  output logic [PW-1:0]  idx
);

  localparam logic [PW-1:0] LAST = PW'(N-1);

  logic [PW-1:0] fp_q, fp_d, cur_q, cur_d;

  always_comb begin
    fp_d  = (fp_q == LAST) ? '0 : fp_q + 1'b1;
    done  = active && (field[2*int'(cur_q) +: 2] == CELL_EMPTY);
    cur_d = cur_q;
    if (start)
      cur_d = fp_q;
    else if (active && !done)
      cur_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
  end

  assign idx = cur_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fp_q  <= '0;
      cur_q <= '0;
    end else begin
      fp_q  <= fp_d;
      cur_q <= cur_d;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// snake_engine: the snake move sequencer.
// On a tick it moves through IDLE -> CHECK -> WAIT -> APPLY -> (FOOD) -> IDLE.
// CHECK sends an external collision/food checker a one-cycle request. WAIT
// gives the checker time to register its verdict. APPLY moves or grows the
// snake, or ends the game. FOOD searches for an empty cell and drops new food there.
//   clk, rst    : clock, synchronous active-low reset
//   tick, key   : move strobe and heading request
//   dead, grow  : checker verdicts, sampled in APPLY
//   check       : one-cycle checker request
//   dir         : current heading
//   snake_xy    : segments, 16 bits each, head at slot 0, unused slots zero
//   field       : 2 bits per cell at x + y*SIZE_X
//   length      : live segment count
//   busy        : high while a move is in flight
//   game_over   : terminal state; only reset leaves it
module snake_engine
  import snake_pkg::*;
#(
  parameter int SIZE_X = 10,
  parameter int SIZE_Y = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [1:0]                      key,
  input  logic                            dead,
  input  logic                            grow,
  output logic                            check,
  output logic [1:0]                      dir,
  output logic [XY_W*SIZE_X*SIZE_Y-1:0]   snake_xy,
  output logic [2*SIZE_X*SIZE_Y-1:0]      field,
  output logic [15:0]                     length,
  output logic                            busy,
  output logic                            game_over
);

  localparam int N  = SIZE_X * SIZE_Y;
  localparam int PW = $clog2(N);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SIZE_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SIZE_Y - 1);
  localparam logic [COORD_W-1:0] Y0    = COORD_W'(SIZE_Y / 2);
  localparam logic [COORD_W-1:0] FX    = COORD_W'(SIZE_X / 2);

  function automatic int cell_of(input logic [XY_W-1:0] xy);
    return int'(xy_x(xy)) + int'(xy_y(xy)) * SIZE_X;
  endfunction

  state_e                    state_q, state_d;
  logic [1:0]                dir_q, dir_d;
  logic [N-1:0][XY_W-1:0]    seg_q, seg_d;
  logic [N-1:0][1:0]         field_q, field_d;
  logic [15:0]               len_q, len_d;
  logic                      check_q, busy_q, over_q;

  logic [COORD_W-1:0]        hx, hy, nx, ny;
  logic [XY_W-1:0]           tail_xy;
  logic                      scan_done;
  logic [PW-1:0]             scan_idx;

  snake_food_scan #(.N(N), .PW(PW)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .start  (state_q == ST_APPLY),
    .active (state_q == ST_FOOD),
    .field  (field_q),
    .done   (scan_done),
    .idx    (scan_idx)
  );

  // Next head position: step the head by dir_q and wrap on the torus.
  always_comb begin
    hx = xy_x(seg_q[0]);
    hy = xy_y(seg_q[0]);
    nx = hx;
    ny = hy;
    case (dir_q)
      KEY_W:   ny = (hy == '0)    ? Y_MAX : hy - 1'b1;
      KEY_S:   ny = (hy == Y_MAX) ? '0    : hy + 1'b1;
      KEY_A:   nx = (hx == '0)    ? X_MAX : hx - 1'b1;
      default: nx = (hx == X_MAX) ? '0    : hx + 1'b1;
    endcase
    tail_xy = seg_q[int'(len_q) - 1];
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    seg_d   = seg_q;
    field_d = field_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: if (tick) begin
        if (!is_reverse(key, dir_q)) dir_d = key;
        state_d = ST_CHECK;
      end
      ST_CHECK: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_APPLY;
      ST_APPLY: begin
        if (dead) begin
          state_d = ST_OVER;
        end else begin
          // Clear the tail before marking the head. A head that steps into
          // the cell the tail just vacated then leaves that cell as body.
          if (!grow) field_d[cell_of(tail_xy)] = CELL_EMPTY;
          for (int i = N - 1; i > 0; i--) seg_d[i] = seg_q[i-1];
          seg_d[0] = pack_xy(nx, ny);
          field_d[int'(nx) + int'(ny) * SIZE_X] = CELL_BODY;
          if (!grow) begin
            if (int'(len_q) < N) seg_d[int'(len_q)] = '0;
            state_d = ST_IDLE;
          end else begin
            len_d   = len_q + 16'd1;
            state_d = (int'(len_q) + 1 == N) ? ST_OVER : ST_FOOD;
          end
        end
      end
      ST_FOOD: if (scan_done) begin
        field_d[int'(scan_idx)] = CELL_FOOD;
        state_d = ST_IDLE;
      end
      default: ;  // ST_OVER holds everything
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= KEY_D;
      len_q   <= 16'd3;
      seg_q   <= '0;
      seg_q[0] <= pack_xy(COORD_W'(2), Y0);
      seg_q[1] <= pack_xy(COORD_W'(1), Y0);
      seg_q[2] <= pack_xy(COORD_W'(0), Y0);
      field_q <= '0;
      field_q[int'(Y0) * SIZE_X + 0] <= CELL_BODY;
      field_q[int'(Y0) * SIZE_X + 1] <= CELL_BODY;
      field_q[int'(Y0) * SIZE_X + 2] <= CELL_BODY;
      field_q[int'(Y0) * SIZE_X + int'(FX)] <= CELL_FOOD;
      check_q <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      seg_q   <= seg_d;
      field_q <= field_d;
      len_q   <= len_d;
      check_q <= (state_d == ST_CHECK);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_OVER);
      over_q  <= (state_d == ST_OVER);
    end
  end

  assign check     = check_q;
  assign dir       = dir_q;
  assign snake_xy  = seg_q;
  assign field     = field_q;
  assign length    = len_q;
  assign busy      = busy_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine on a 10x10 field. A reference model tracks the snake
// as a coordinate queue (head at the front) and the field as a cell array. It
// applies the game rules directly, with modular arithmetic for the wrap.
module tb_snake_engine;

  localparam int SX = 10;
  localparam int SY = 10;
  localparam int N  = SX * SY;

  logic             clk, rst, tick, dead, grow;
  logic [1:0]       key;
  logic             check, busy, game_over;
  logic [1:0]       dir;
  logic [16*N-1:0]  snake_xy;
  logic [2*N-1:0]   field;
  logic [15:0]      length;

  snake_engine #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key), .dead(dead), .grow(grow),
    .check(check), .dir(dir), .snake_xy(snake_xy), .field(field),
    .length(length), .busy(busy), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // The scan pointer runs freely from 0 at reset, so its value is the number
  // of clock edges since reset, modulo N.
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int qx[$];
  int qy[$];
  int fld[N];
  int mdir;
  bit mover;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    qx = {2, 1, 0};
    qy = {SY/2, SY/2, SY/2};
    foreach (fld[i]) fld[i] = 0;
    for (int i = 0; i < 3; i++) fld[i + SX*(SY/2)] = 1;
    fld[SX/2 + SX*(SY/2)] = 2;
    mdir  = 2;
    mover = 0;
  endtask

  task automatic full_cmp(input string t);
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      e = (i < qx.size()) ? {8'(qy[i]), 8'(qx[i])} : 16'h0;
      chk($sformatf("%s seg%0d", t, i), 32'(snake_xy[16*i +: 16]), 32'(e));
      chk($sformatf("%s cell%0d", t, i), 32'(field[2*i +: 2]), fld[i]);
    end
    chk({t, " length"}, 32'(length), qx.size());
    chk({t, " dir"}, 32'(dir), mdir);
    chk({t, " game_over"}, 32'(game_over), 32'(mover));
    chk({t, " busy"}, 32'(busy), 0);
    chk({t, " check"}, 32'(check), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick = 1'b0; grow = 1'b0; dead = 1'b0; key = 2'b00;
    @(negedge clk);
    model_reset();
    full_cmp("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one move starting from IDLE at a negedge. When noise is set, tick stays
  // high through the busy phase, which must have no effect. When rst_food is set,
  // reset hits during the first FOOD cycle.
  task automatic do_move(input logic [1:0] k, input bit g, input bit d,
                         input bit noise, input bit rst_food, input string t);
    int fp_apply;
    int hx, hy;
    bit food;
    int n;
    key = k; grow = g; dead = d; tick = 1'b1;
    if (int'(k) + mdir != 3) mdir = k;  // opposite pairs are 0/3 and 1/2
    @(negedge clk);
    tick = noise;
    chk({t, " check_pulse"}, 32'(check), 1);
    chk({t, " busy_move"}, 32'(busy), 1);
    @(negedge clk);
    chk({t, " check_once"}, 32'(check), 0);
    @(negedge clk);
    chk({t, " check_wait"}, 32'(check), 0);
    fp_apply = cyc % N;
    @(negedge clk);
    food = 0;
    if (d) begin
      mover = 1;
    end else begin
      hx = qx[0]; hy = qy[0];
      case (mdir)
        0:       hy = (hy + SY - 1) % SY;
        1:       hx = (hx + SX - 1) % SX;
        3:       hy = (hy + 1) % SY;
        default: hx = (hx + 1) % SX;
      endcase
      if (!g) begin
        fld[qx[$] + SX*qy[$]] = 0;
        void'(qx.pop_back());
        void'(qy.pop_back());
      end
      qx.push_front(hx);
      qy.push_front(hy);
      fld[hx + SX*hy] = 1;
      if (g) begin
        if (qx.size() == N) mover = 1;
        else food = 1;
      end
    end
    if (food && rst_food) begin
      rst = 1'b0; tick = 1'b0;
      @(negedge clk);
      model_reset();
      full_cmp({t, " rst_in_food"});
      rst = 1'b1;
      return;
    end
    if (!food) begin
      tick = 1'b0;
    end else begin
      @(negedge clk);
      tick = 1'b0;
      n = 1;
      while (busy && n < N + 2) begin
        @(negedge clk);
        n++;
      end
      chk({t, " food_bound"}, 32'(busy), 0);
      for (int j = 0; j < N; j++) begin
        int c;
        c = (fp_apply + j) % N;
        if (fld[c] == 0) begin
          fld[c] = 2;
          break;
        end
      end
    end
    @(negedge clk);
    full_cmp(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; tick = 1'b0; grow = 1'b0; dead = 1'b0; key = 2'b00;
    do_reset();
    chk("reset head", 32'(snake_xy[15:0]), 32'h0502);

    do_move(2'b10, 0, 0, 0, 0, "step_d");
    chk("step_d head", 32'(snake_xy[15:0]), 32'h0503);
    chk("step_d tail_cleared", 32'(field[2*50 +: 2]), 0);

    do_move(2'b10, 0, 0, 0, 0, "step_d2");
    do_move(2'b10, 1, 0, 1, 0, "eat");
    chk("eat head", 32'(snake_xy[15:0]), 32'h0505);
    chk("eat length", 32'(length), 4);

    do_move(2'b01, 0, 0, 0, 0, "reverse");
    chk("reverse dir", 32'(dir), 32'h2);

    for (int i = 0; i < 8; i++) do_move(2'b00, 0, 0, i[0], 0, "wrap_w");
    for (int i = 0; i < 8; i++) do_move(2'b01, (i == 3), 0, 0, 0, "wrap_a");
    for (int i = 0; i < 25; i++)
      do_move(2'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0), 0,
              1'($urandom_range(1, 0)), 0, "rand");

    do_move(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1, 0, 0, "dead");
    chk("dead game_over", 32'(game_over), 1);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; key = 2'($urandom_range(3, 0));
      @(negedge clk);
      chk("over check", 32'(check), 0);
      chk("over busy", 32'(busy), 0);
    end
    tick = 1'b0;
    full_cmp("over_hold");

    do_reset();
    do_move(2'b10, 1, 0, 0, 1, "food_reset");
    chk("food_reset head", 32'(snake_xy[15:0]), 32'h0502);
    @(negedge clk);
    full_cmp("after_food_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
